// File: rtl/rtc_read_ctrl_if.sv
// ---------------------------------------------------------------------------
// rtc_read_ctrl_if
//   Pad-side bus of the external real-time-clock chip: active-low chip
//   select and strobes plus the multiplexed 8-bit address/data bus.
//
//   cs_n    chip select, active-low
//   rd_n    read strobe, active-low
//   wr_n    write (address) strobe, active-low
//   ad_sel  address/data select: 0 = address, 1 = data
//   ad_out  address byte driven towards the pad
//   ad_oe   pad output enable for ad_out
//   ad_in   data byte returned from the pad
//
//   master: the read controller.  slave: the RTC chip / pad model.
// ---------------------------------------------------------------------------
interface rtc_read_ctrl_if;
  logic       cs_n;
  logic       rd_n;
  logic       wr_n;
  logic       ad_sel;
  logic [7:0] ad_out;
  logic       ad_oe;
  logic [7:0] ad_in;

  modport master (
    output cs_n, rd_n, wr_n, ad_sel, ad_out, ad_oe,
    input  ad_in
  );

  modport slave (
    input  cs_n, rd_n, wr_n, ad_sel, ad_out, ad_oe,
    output ad_in
  );
endinterface

// File: rtl/rtc_read_ctrl.sv
// ---------------------------------------------------------------------------
// rtc_read_ctrl
//   Reads the six time/date registers (seconds, minutes, hours, day, month,
//   year) of the external RTC over its multiplexed address/data bus after a
//   start pulse, converts each BCD byte to binary and holds the results as
//   7-bit values for the display/compare logic.
//
//   Each register costs four bus phases of T_PHASE cycles each:
//   ADDR (address out, wr_n low), GAP1, DATA (rd_n low, sample ad_in on the
//   last cycle), GAP2.  A one-cycle DONE state follows the sixth register.
//
//   clk      system clock, rising edge
//   reset    asynchronous, active-high
//   start    one-cycle request, accepted only when idle
//   busy     high while the bus sequence runs
//   done     one-cycle pulse after the last register
//   err      sticky: a byte in this sequence was not valid BCD
//   bus      RTC pad bus (master side)
//   seg_sal, min_sal, hor_sal, dia_sal, mes_sal, an_sal
//            binary register values 0..99
// ---------------------------------------------------------------------------
module rtc_read_ctrl #(
  parameter int         T_PHASE   = 4,      // cycles per bus phase, 2..255
  parameter logic [7:0] ADDR_BASE = 8'h21   // address of the seconds register
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  rtc_read_ctrl_if.master       bus,
  output logic [6:0]            seg_sal,
  output logic [6:0]            min_sal,
  output logic [6:0]            hor_sal,
  output logic [6:0]            dia_sal,
  output logic [6:0]            mes_sal,
  output logic [6:0]            an_sal
);

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    GAP1,
    DATA,
    GAP2,
    DONE
  } state_t;

  localparam logic [7:0] PH_LAST  = 8'(T_PHASE - 1);
  localparam logic [2:0] IDX_LAST = 3'd5;   // year
  localparam logic [2:0] IDX_HOUR = 3'd2;

  state_t     state;
  state_t     state_nxt;
  logic [7:0] ph_cnt;
  logic [2:0] idx;
  logic       ph_end;
  logic       accept;
  logic       sample;

  // Bus outputs decoded from the state.
  logic       cs_n_c;
  logic       rd_n_c;
  logic       wr_n_c;
  logic       ad_sel_c;
  logic       ad_oe_c;
  logic [7:0] ad_out_c;

  // BCD conversion of the byte on the bus.
  logic [7:0] byte_m;
  logic [3:0] tens;
  logic [3:0] units;
  logic       bcd_ok;
  logic [6:0] bcd_val;

  assign ph_end = (ph_cnt == PH_LAST);
  assign accept = (state == IDLE) && start;
  assign sample = (state == DATA) && ph_end;

  // -------------------------------------------------------------------------
  // Next state and decoded outputs
  // -------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no branch can
    // leave one unassigned and infer a latch.
    state_nxt = state;
    cs_n_c    = 1'b1;
    rd_n_c    = 1'b1;
    wr_n_c    = 1'b1;
    ad_sel_c  = 1'b0;
    ad_oe_c   = 1'b0;
    ad_out_c  = 8'h00;
    busy      = 1'b0;
    done      = 1'b0;

    case (state)
      IDLE: begin
        if (start) state_nxt = ADDR;
      end
      ADDR: begin
        cs_n_c   = 1'b0;
        wr_n_c   = 1'b0;
        ad_oe_c  = 1'b1;
        ad_out_c = ADDR_BASE + {5'd0, idx};
        busy     = 1'b1;
        if (ph_end) state_nxt = GAP1;
      end
      GAP1: begin
        busy = 1'b1;
        if (ph_end) state_nxt = DATA;
      end
      DATA: begin
        cs_n_c   = 1'b0;
        rd_n_c   = 1'b0;
        ad_sel_c = 1'b1;
        busy     = 1'b1;
        if (ph_end) state_nxt = GAP2;
      end
      GAP2: begin
        busy = 1'b1;
        if (ph_end) state_nxt = (idx == IDX_LAST) ? DONE : ADDR;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.cs_n   = cs_n_c;
  assign bus.rd_n   = rd_n_c;
  assign bus.wr_n   = wr_n_c;
  assign bus.ad_sel = ad_sel_c;
  assign bus.ad_oe  = ad_oe_c;
  assign bus.ad_out = ad_out_c;

  // -------------------------------------------------------------------------
  // BCD decode; the hours register carries 12/24 h flags in bits [7:6].
  // -------------------------------------------------------------------------
  always_comb begin
    byte_m = bus.ad_in;
    if (idx == IDX_HOUR) byte_m[7:6] = 2'b00;
    tens    = byte_m[7:4];
    units   = byte_m[3:0];
    bcd_ok  = (tens <= 4'd9) && (units <= 4'd9);
    bcd_val = 7'(tens) * 7'd10 + 7'(units);
  end

  // -------------------------------------------------------------------------
  // State, phase counter and register index
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      ph_cnt <= 8'd0;
      idx    <= 3'd0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register here sees the pre-edge values of the others.
      state <= state_nxt;

      // The counter restarts at every phase change and rests at 0 when idle.
      if (state_nxt != state) ph_cnt <= 8'd0;
      else if (busy)          ph_cnt <= ph_cnt + 8'd1;

      if (accept)
        idx <= 3'd0;
      else if ((state == GAP2) && ph_end && (idx != IDX_LAST))
        idx <= idx + 3'd1;
    end
  end

  // -------------------------------------------------------------------------
  // Error flag and converted values
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: the six values are individual flops, not a RAM, so they can
      // clear on reset like any other register.
      err     <= 1'b0;
      seg_sal <= 7'd0;
      min_sal <= 7'd0;
      hor_sal <= 7'd0;
      dia_sal <= 7'd0;
      mes_sal <= 7'd0;
      an_sal  <= 7'd0;
    end else begin
      if (accept)
        err <= 1'b0;
      else if (sample && !bcd_ok)
        err <= 1'b1;

      // An invalid byte leaves the previous value in place.
      if (sample && bcd_ok) begin
        case (idx)
          3'd0:    seg_sal <= bcd_val;
          3'd1:    min_sal <= bcd_val;
          3'd2:    hor_sal <= bcd_val;
          3'd3:    dia_sal <= bcd_val;
          3'd4:    mes_sal <= bcd_val;
          3'd5:    an_sal  <= bcd_val;
          default: ;
        endcase
      end
    end
  end

endmodule
